bf_program_sequencer: RTL and testbench
=======================================

BF_PROGRAM_SEQUENCER -- requirements
Module: bf_program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_SIZE_CODE, default 9, giving the code RAM address width; DEPTH = 2**ADDR_SIZE_CODE.
REQ-002 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports host_start in 1 (begin load), host_run in 1 (start execution), host_valid in 1, host_data in 8, and host_ready out 1.
REQ-005 SHALL have ports core_reset_n out 1 (to core reset), core_addr_code in ADDR_SIZE_CODE, and core_data_code out 8.
REQ-006 SHALL have ports ram_addr out ADDR_SIZE_CODE, ram_wdata out 8, ram_we out 1, and ram_rdata in 8 (asynchronous-read code RAM).
REQ-007 SHALL have ports state out 2, load_len out ADDR_SIZE_CODE (bytes written, terminator excluded), load_overflow out 1, and run_cycles out 32.

Function
REQ-008 SHALL implement an FSM with states IDLE=0, LOAD=1, RUN=2, HALT=3, output on state.
REQ-009 IDLE: host_start -> LOAD, write pointer cleared, load_overflow cleared; otherwise host_run -> RUN; host_start has priority.
REQ-010 LOAD: host_ready=1 while pointer < DEPTH-1; a beat is accepted when host_valid && host_ready; it drives ram_we=1, ram_addr=pointer, ram_wdata=host_data in the same cycle.
REQ-011 LOAD, non-zero byte accepted: pointer and load_len increment by 1.
REQ-012 LOAD, 0x00 byte accepted: the byte is written, load_len is unchanged, and the next state is IDLE.
REQ-013 LOAD, pointer == DEPTH-1: host_ready=0; 0x00 is written at DEPTH-1 automatically; load_overflow=1; the next state is IDLE.
REQ-014 LOAD: host_start and host_run are ignored.
REQ-015 RUN: ram_addr=core_addr_code, core_data_code=ram_rdata (combinational), ram_we=0, host_ready=0.
REQ-016 core_reset_n SHALL be registered, equal to 1 only when state was RUN in the previous cycle and is RUN now, so every entry to RUN gives the core at least one reset cycle.
REQ-017 Halt detection: in RUN with core_reset_n=1, a 2-bit counter increments when ram_rdata==0x00 and core_addr_code equals its previous-cycle value, else clears; reaching 3 -> HALT.
REQ-018 HALT: core_reset_n stays 1; host_run -> RUN (restart from address 0 via REQ-016); host_start -> LOAD.
REQ-019 RUN or HALT, host_start -> LOAD; core_reset_n drops to 0 on the next edge; load_len, pointer and load_overflow clear.
REQ-020 Outside RUN, core_data_code SHALL be 0x00.
REQ-021 Outside LOAD, ram_we SHALL be 0.

Reset
REQ-022 reset==0 at a clock edge SHALL force the following values: state=IDLE, core_reset_n=0, host_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, load_len=0, load_overflow=0, halt counter=0, run_cycles=0, core_data_code=0.
REQ-023 Reset mid-LOAD SHALL abandon the load without writing a terminator.

Configuration
REQ-024 Macro BF_SEQ_CYCLE_COUNT_EN is defined: run_cycles SHALL clear on entry to RUN, increment by 1 each RUN cycle with core_reset_n=1, saturate at 0xFFFFFFFF, and hold in HALT/IDLE.
REQ-025 Macro BF_SEQ_CYCLE_COUNT_EN is undefined: run_cycles SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-026 Shared package bf_pkg SHALL hold the state enum (IDLE/LOAD/RUN/HALT) and the opcode constants, including the terminator OP_NULL=8'h00.
REQ-027 The halt detector (REQ-017) SHALL be a sub-module bf_halt_detect, inputs addr/data/enable, output halted.
REQ-028 The FSM and the RAM port mux SHALL stay in bf_program_sequencer.

Verification
REQ-029 Load test: load "+.", then 0x00 -> RAM[0..2]=2B,2E,00; load_len=2; state returns to IDLE; load_overflow=0.
REQ-030 Overflow test: ADDR_SIZE_CODE=3, stream 10 non-zero bytes with host_valid held -> 7 accepted; RAM[7]=00; load_overflow=1; host_ready=0 from the cycle pointer hits 7.
REQ-031 Run/halt test: program "+.", 0x00, then host_run -> core_reset_n=0 for the first RUN cycle, then 1; state reaches HALT at most 8 cycles after core_addr_code reaches 2.
REQ-032 Abort test: host_start pulsed during RUN -> next cycle state=LOAD and core_reset_n=0; load_len=0.
REQ-033 Reset test: reset low for 1 cycle during LOAD after 3 beats -> all REQ-022 values hold; RAM[3] is unwritten.
REQ-034 Cycle count test (BF_SEQ_CYCLE_COUNT_EN): two successive runs of the same program -> equal run_cycles; HALT holds the value.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the BF program sequencer: state encoding, opcodes, widths.
package bf_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned RUN_CYC_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } bf_state_e;

    localparam logic [BYTE_W-1:0] OP_NULL  = 8'h00;
    localparam logic [BYTE_W-1:0] OP_INC   = 8'h2B;
    localparam logic [BYTE_W-1:0] OP_IN    = 8'h2C;
    localparam logic [BYTE_W-1:0] OP_DEC   = 8'h2D;
    localparam logic [BYTE_W-1:0] OP_OUT   = 8'h2E;
    localparam logic [BYTE_W-1:0] OP_LEFT  = 8'h3C;
    localparam logic [BYTE_W-1:0] OP_RIGHT = 8'h3E;
    localparam logic [BYTE_W-1:0] OP_JZ    = 8'h5B;
    localparam logic [BYTE_W-1:0] OP_JNZ   = 8'h5D;

    function automatic logic is_terminator(input logic [BYTE_W-1:0] b);
        return b == OP_NULL;
    endfunction

endpackage

// File: rtl/bf_halt_detect.sv
// Halt detector: flags a core that has sat on a terminator byte at the same
// address for three consecutive enabled cycles.
module bf_halt_detect
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] data,
    input  logic              enable,
    output logic              halted
);

    localparam logic [1:0] CNT_MAX = 2'd3;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              stuck_c;

    // Count consecutive cycles parked on a terminator; any other cycle restarts the count.
    always_comb begin
        cnt_d   = 2'd0;
        stuck_c = enable && is_terminator(data) && (addr == addr_q);
        if (stuck_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 2'd1;
        end
    end

    // Previous-cycle address and the stuck counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            addr_q <= addr;
            cnt_q  <= cnt_d;
        end
    end

    assign halted = (cnt_q == CNT_MAX);

endmodule

// File: rtl/bf_program_sequencer.sv
// BF program sequencer: loads a null-terminated program from the host into the
// code RAM, then runs the core against it and detects when it halts.
// Optional feature macro: BF_SEQ_CYCLE_COUNT_EN (run_cycles counter).
module bf_program_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_SIZE_CODE = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_start,
    input  logic                      host_run,
    input  logic                      host_valid,
    input  logic [BYTE_W-1:0]         host_data,
    output logic                      host_ready,
    output logic                      core_reset_n,
    input  logic [ADDR_SIZE_CODE-1:0] core_addr_code,
    output logic [BYTE_W-1:0]         core_data_code,
    output logic [ADDR_SIZE_CODE-1:0] ram_addr,
    output logic [BYTE_W-1:0]         ram_wdata,
    output logic                      ram_we,
    input  logic [BYTE_W-1:0]         ram_rdata,
    output logic [STATE_W-1:0]        state,
    output logic [ADDR_SIZE_CODE-1:0] load_len,
    output logic                      load_overflow,
    output logic [RUN_CYC_W-1:0]      run_cycles
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE_CODE;
    localparam logic [ADDR_SIZE_CODE-1:0] PTR_LAST = ADDR_SIZE_CODE'(DEPTH - 1);

    localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
    localparam logic [STATE_W-1:0] S_LOAD = ST_LOAD;
    localparam logic [STATE_W-1:0] S_RUN  = ST_RUN;
    localparam logic [STATE_W-1:0] S_HALT = ST_HALT;

    logic [STATE_W-1:0]        state_q;
    logic [STATE_W-1:0]        state_d;
    logic [ADDR_SIZE_CODE-1:0] ptr_q;
    logic [ADDR_SIZE_CODE-1:0] ptr_d;
    logic                      ovf_q;
    logic                      ovf_d;
    logic                      crn_q;
    logic                      crn_d;
    logic                      halted;
    logic                      halt_en_c;

    // State, write pointer, overflow flag and core reset release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            crn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            crn_q   <= crn_d;
        end
    end

    // Next-state logic and the shared RAM port mux (host writes in LOAD, core reads in RUN).
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        ovf_d          = ovf_q;
        host_ready     = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = ptr_q;
        ram_wdata      = OP_NULL;
        core_data_code = OP_NULL;

        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else if (host_run) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (ptr_q == PTR_LAST) begin
                    // Last slot is reserved for a forced terminator.
                    ram_we    = reset;
                    ram_wdata = OP_NULL;
                    ovf_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    host_ready = reset;
                    if (host_valid && host_ready) begin
                        ram_we    = 1'b1;
                        ram_wdata = host_data;
                        if (is_terminator(host_data)) begin
                            state_d = S_IDLE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                ram_addr       = core_addr_code;
                core_data_code = ram_rdata;
                if (host_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else if (halted) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (host_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else if (host_run) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Core leaves reset only after a full cycle in RUN; HALT keeps it out of reset.
        crn_d = ((state_q == S_RUN) && (state_d == S_RUN)) || (state_d == S_HALT);
    end

    assign halt_en_c = (state_q == S_RUN) && crn_q;

    bf_halt_detect #(
        .ADDR_W (ADDR_SIZE_CODE)
    ) u_halt_detect (
        .clk    (clk),
        .reset  (reset),
        .addr   (core_addr_code),
        .data   (ram_rdata),
        .enable (halt_en_c),
        .halted (halted)
    );

    assign state         = state_q;
    assign load_len      = ptr_q;
    assign load_overflow = ovf_q;
    assign core_reset_n  = crn_q;

`ifdef BF_SEQ_CYCLE_COUNT_EN
    logic [RUN_CYC_W-1:0] cyc_q;

    // Count cycles the core actually executes; restart on each RUN entry, saturate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if ((state_q != S_RUN) && (state_d == S_RUN)) begin
            cyc_q <= '0;
        end else if (halt_en_c && (cyc_q != {RUN_CYC_W{1'b1}})) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign run_cycles = cyc_q;
`else
    assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_bf_program_sequencer.sv
// Self-checking bench for bf_program_sequencer: host loads, runs, halts, aborts,
// overflow and reset, with a small core model and an external code RAM.
module tb_bf_program_sequencer;

    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [7:0]  FILL  = 8'hA5;

    logic          clk;
    logic          reset;
    logic          host_start;
    logic          host_run;
    logic          host_valid;
    logic [7:0]    host_data;
    logic          host_ready;
    logic          core_reset_n;
    logic [AW-1:0] core_addr_code;
    logic [7:0]    core_data_code;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;
    logic [1:0]    state;
    logic [AW-1:0] load_len;
    logic          load_overflow;
    logic [31:0]   run_cycles;

    bf_program_sequencer #(.ADDR_SIZE_CODE(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .host_start     (host_start),
        .host_run       (host_run),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_ready     (host_ready),
        .core_reset_n   (core_reset_n),
        .core_addr_code (core_addr_code),
        .core_data_code (core_data_code),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata),
        .state          (state),
        .load_len       (load_len),
        .load_overflow  (load_overflow),
        .run_cycles     (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code RAM: asynchronous read, synchronous write, bulk fill for "unwritten" marking.
    logic [7:0] mem [0:DEPTH-1];
    logic       fill_req;
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= FILL;
        end else if (ram_we === 1'b1) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    // Core model: advances while fetching non-null bytes, parks on a null.
    logic [AW-1:0] pc;
    always @(posedge clk) begin
        if (core_reset_n !== 1'b1) pc <= '0;
        else if (core_data_code != 8'h00) pc <= pc + 1'b1;
    end
    assign core_addr_code = pc;

    int         checks;
    int         errors;
    int         mon_checks;
    int         mon_errors;
    logic [15:0] exp_q [$];
    logic [7:0]  prog_q [$];
    logic [7:0]  img [0:DEPTH-1];
    int          exp_len;
    int          exp_ovf;

    // Scoreboard monitor: every RAM write must match the next expected write.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL ram_write unexpected addr=%0d data=%02h (no write expected)", ram_addr, ram_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({8'(ram_addr), ram_wdata} !== e) begin
                    mon_errors++;
                    $display("FAIL ram_write got addr=%0d data=%02h want addr=%0d data=%02h",
                             ram_addr, ram_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) img[i] = FILL;
    endtask

    // Reference model of a load: which writes happen, final length and overflow.
    task automatic model_load(input int limit);
        int  idx;
        bit  term;
        idx  = 0;
        term = 0;
        exp_ovf = 0;
        for (int i = 0; i < prog_q.size(); i++) begin
            if (limit >= 0 && i >= limit) break;
            if (idx == DEPTH - 1) break;
            exp_q.push_back({8'(idx), prog_q[i]});
            img[idx] = prog_q[i];
            if (prog_q[i] == 8'h00) begin
                term = 1;
                break;
            end
            idx++;
        end
        if (!term && limit < 0 && idx == DEPTH - 1) begin
            exp_q.push_back({8'(idx), 8'h00});
            img[idx] = 8'h00;
            exp_ovf  = 1;
        end
        exp_len = idx;
    endtask

    // Host driver: start a load and stream prog_q with random gaps and ignored commands.
    task automatic do_load(input int limit);
        int acc_cnt;
        int cyc;
        bit acc;
        model_load(limit);
        host_start = 1'b1;
        host_run   = 1'b0;
        host_valid = 1'b0;
        tick();
        host_start = 1'b0;
        chk("start_state", 32'(state), 32'd1);
        chk("start_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("start_load_len", 32'(load_len), 32'd0);
        chk("start_overflow", 32'(load_overflow), 32'd0);
        acc_cnt = 0;
        cyc     = 0;
        while (state == 2'd1 && !(limit >= 0 && acc_cnt >= limit) && cyc < 200) begin
            host_start = 1'($urandom_range(0, 1));
            host_run   = 1'($urandom_range(0, 1));
            if (acc_cnt < prog_q.size() && $urandom_range(0, 3) != 0) begin
                host_valid = 1'b1;
                host_data  = prog_q[acc_cnt];
            end else begin
                host_valid = 1'b0;
                host_data  = 8'($urandom);
            end
            @(negedge clk);
            chk("host_ready", 32'(host_ready), 32'(acc_cnt < DEPTH - 1));
            acc = host_valid && host_ready;
            tick();
            if (acc) acc_cnt++;
            cyc++;
        end
        host_start = 1'b0;
        host_run   = 1'b0;
        host_valid = 1'b0;
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL load_timeout got state=%0d after %0d cycles want IDLE", state, cyc);
        end
    endtask

    task automatic check_loaded();
        chk("load_state_idle", 32'(state), 32'd0);
        chk("load_len", 32'(load_len), 32'(exp_len));
        chk("load_overflow", 32'(load_overflow), 32'(exp_ovf));
        for (int i = 0; i <= exp_len && i < DEPTH; i++) chk("ram_image", 32'(mem[i]), 32'(img[i]));
    endtask

    // Run the loaded program to HALT and check reset release, fetch path and halt.
    task automatic run_prog(output logic [31:0] rc);
        int cyc;
        int since;
        bit seen;
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        chk("run_state", 32'(state), 32'd2);
        chk("run_first_core_reset_n", 32'(core_reset_n), 32'd0);
        tick();
        chk("run_second_core_reset_n", 32'(core_reset_n), 32'd1);
        cyc   = 0;
        since = 0;
        seen  = 0;
        while (state != 2'd3 && cyc < 100) begin
            if (state == 2'd2) chk("core_data_code", 32'(core_data_code), 32'(img[core_addr_code]));
            if (!seen && core_reset_n && 32'(core_addr_code) == 32'(exp_len)) seen = 1;
            tick();
            cyc++;
            if (seen) since++;
        end
        if (cyc >= 100) begin
            checks++;
            errors++;
            $display("FAIL halt_timeout got state=%0d want HALT", state);
        end
        chk("halt_latency_le8", 32'(since <= 8), 32'd1);
        chk("halt_addr", 32'(core_addr_code), 32'(exp_len));
        chk("halt_core_reset_n", 32'(core_reset_n), 32'd1);
        chk("halt_core_data", 32'(core_data_code), 32'd0);
        chk("halt_ram_we", 32'(ram_we), 32'd0);
        rc = run_cycles;
        repeat (3) tick();
        chk("halt_hold_state", 32'(state), 32'd3);
        chk("halt_hold_cycles", run_cycles, rc);
`ifdef BF_SEQ_CYCLE_COUNT_EN
        chk("run_cycles_nonzero", 32'(rc != 0), 32'd1);
`else
        chk("run_cycles_zero", run_cycles, 32'd0);
`endif
    endtask

    task automatic check_reset_vals();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_load_len", 32'(load_len), 32'd0);
        chk("rst_overflow", 32'(load_overflow), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_core_data", 32'(core_data_code), 32'd0);
    endtask

    initial begin
        logic [31:0] rc1;
        logic [31:0] rc2;
        int          n;
        checks     = 0;
        errors     = 0;
        mon_checks = 0;
        mon_errors = 0;
        reset      = 1'b0;
        host_start = 1'b0;
        host_run   = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        fill_req   = 1'b1;
        repeat (2) tick();
        fill_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) img[i] = FILL;
        reset = 1'b1;
        check_reset_vals();

        // "+." then terminator
        prog_q = '{8'h2B, 8'h2E, 8'h00};
        do_load(-1);
        check_loaded();
        chk("load_ram2_null", 32'(mem[2]), 32'd0);
        run_prog(rc1);
        run_prog(rc2);
`ifdef BF_SEQ_CYCLE_COUNT_EN
        chk("run_cycles_repeat", rc2, rc1);
`endif

        // Abort a running program with a new load
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        tick();
        prog_q = '{8'h3E, 8'h00};
        do_load(-1);
        check_loaded();

        // Overflow: ten non-null bytes into an 8-deep RAM
        prog_q.delete();
        for (int i = 0; i < 10; i++) prog_q.push_back(8'($urandom_range(1, 255)));
        do_load(-1);
        check_loaded();
        chk("ovf_ram_last_null", 32'(mem[DEPTH-1]), 32'd0);
        run_prog(rc1);

        // Random programs, each run twice
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 9);
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom_range(1, 255)));
            if (n < DEPTH - 1) prog_q.push_back(8'h00);
            do_load(-1);
            check_loaded();
            run_prog(rc1);
            run_prog(rc2);
`ifdef BF_SEQ_CYCLE_COUNT_EN
            chk("rand_run_cycles_repeat", rc2, rc1);
`endif
        end

        // Reset in the middle of a load after three beats
        do_fill();
        prog_q = '{8'h2B, 8'h2D, 8'h3C, 8'h5B, 8'h5D, 8'h00};
        do_load(3);
        chk("pre_reset_state", 32'(state), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_vals();
        chk("rst_ram3_unwritten", 32'(mem[3]), 32'(FILL));
        repeat (2) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
